// File: rtl/swo_uart_rx_pkg.sv
// Shared constants for the SWO UART receiver: FSM encodings, framing limits
// and the configuration clamp helpers applied when a frame starts.
package swo_uart_rx_pkg;

  localparam logic [2:0] SWO_RX_IDLE      = 3'd0;
  localparam logic [2:0] SWO_RX_START     = 3'd1;
  localparam logic [2:0] SWO_RX_DATA      = 3'd2;
  localparam logic [2:0] SWO_RX_STOP      = 3'd3;
  localparam logic [2:0] SWO_RX_WAIT_HIGH = 3'd4;

  localparam logic [3:0] DATA_BITS_MIN = 4'd5;
  localparam logic [3:0] DATA_BITS_MAX = 4'd8;
  localparam logic [1:0] STOP_BITS_MIN = 2'd1;
  localparam logic [1:0] STOP_BITS_MAX = 2'd2;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
    if (bits < DATA_BITS_MIN || bits > DATA_BITS_MAX) return DATA_BITS_MAX;
    return bits;
  endfunction

  function automatic logic [1:0] clamp_stop_bits(input logic [1:0] bits);
    if (bits < STOP_BITS_MIN) return STOP_BITS_MIN;
    if (bits > STOP_BITS_MAX) return STOP_BITS_MAX;
    return bits;
  endfunction

endpackage

// File: rtl/swo_uart_rx_if.sv
// Received-byte bus from the SWO receiver to the trace trigger matcher.
interface swo_uart_rx_if;

  logic [7:0] O_data;
  logic       O_data_valid;
  logic       O_framing_error;
  logic       O_busy;

  modport master (output O_data, output O_data_valid, output O_framing_error, output O_busy);
  modport slave  (input  O_data, input  O_data_valid, input  O_framing_error, input  O_busy);

endinterface

// File: rtl/swo_uart_rx_bit_timer.sv
// Loadable down-counter that parks at zero; zero marks a bit sample point.
module swo_uart_rx_bit_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/swo_uart_rx.sv
// SWO NRZ/UART receiver: synchronizes the pin, deframes LSB-first bytes and
// emits one-cycle strobes. Define SWO_RX_STATS_EN to build the saturating counters.
module swo_uart_rx
  import swo_uart_rx_pkg::*;
#(
  parameter int pDIV_WIDTH = 8,
  parameter int pCNT_WIDTH = 16
) (
  input  logic                  uart_clk,
  input  logic                  reset_i,
  input  logic                  I_swo,
  input  logic                  I_swo_enable,
  input  logic [pDIV_WIDTH-1:0] I_bitrate_div,
  input  logic [1:0]            I_stop_bits,
  input  logic [3:0]            I_data_bits,
  swo_uart_rx_if.master         rx_bus,
  output logic [pCNT_WIDTH-1:0] O_byte_count,
  output logic [pCNT_WIDTH-1:0] O_error_count
);

  localparam int PW = pDIV_WIDTH + 1;

  logic                  sync1_q, swo_s_q, swo_prev_q;
  logic [2:0]            state_q, state_d;
  logic [PW-1:0]         period_q, period_d;
  logic [3:0]            nbits_q, nbits_d;
  logic [1:0]            nstop_q, nstop_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;

  logic                  tmr_load;
  logic [PW-1:0]         tmr_val;
  logic                  tmr_zero;
  logic [pDIV_WIDTH-1:0] div_clamped;
  logic [PW-1:0]         period_new;

  assign div_clamped = (I_bitrate_div == '0) ? {{(pDIV_WIDTH-1){1'b0}}, 1'b1} : I_bitrate_div;
  assign period_new  = {1'b0, div_clamped} + 1'b1;

  swo_uart_rx_bit_timer #(.W(PW)) u_bit_timer (
    .clk      (uart_clk),
    .rst      (reset_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    nbits_d    = nbits_q;
    nstop_d    = nstop_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = period_q - 1'b1;

    case (state_q)
      SWO_RX_IDLE: begin
        // Configuration is captured here so mid-frame register writes cannot corrupt a byte.
        if (I_swo_enable && !swo_s_q && swo_prev_q) begin
          state_d  = SWO_RX_START;
          period_d = period_new;
          nbits_d  = clamp_data_bits(I_data_bits);
          nstop_d  = clamp_stop_bits(I_stop_bits);
          tmr_load = 1'b1;
          tmr_val  = (period_new >> 1) - 1'b1;
        end
      end
      SWO_RX_START: begin
        if (tmr_zero) begin
          if (!swo_s_q) begin
            state_d   = SWO_RX_DATA;
            bit_idx_d = 3'd0;
            shift_d   = 8'h00;
            tmr_load  = 1'b1;
          end else begin
            state_d = SWO_RX_IDLE;
          end
        end
      end
      SWO_RX_DATA: begin
        if (tmr_zero) begin
          shift_d[bit_idx_q] = swo_s_q;
          tmr_load           = 1'b1;
          if ({1'b0, bit_idx_q} == nbits_q - 4'd1) begin
            state_d    = SWO_RX_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      SWO_RX_STOP: begin
        if (tmr_zero) begin
          if (!swo_s_q) begin
            ferr_d  = 1'b1;
            state_d = SWO_RX_WAIT_HIGH;
          end else if ({1'b0, stop_idx_q} == nstop_q - 2'd1) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            state_d = SWO_RX_IDLE;
          end else begin
            stop_idx_d = 1'b1;
            tmr_load   = 1'b1;
          end
        end
      end
      SWO_RX_WAIT_HIGH: begin
        if (swo_s_q) state_d = SWO_RX_IDLE;
      end
      default: state_d = SWO_RX_IDLE;
    endcase

    // Disabling the receiver drops any partial byte without a strobe.
    if (!I_swo_enable) begin
      state_d  = SWO_RX_IDLE;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      data_d   = data_q;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (reset_i) begin
      sync1_q    <= 1'b1;
      swo_s_q    <= 1'b1;
      swo_prev_q <= 1'b1;
      state_q    <= SWO_RX_IDLE;
      period_q   <= '0;
      nbits_q    <= DATA_BITS_MAX;
      nstop_q    <= STOP_BITS_MIN;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= I_swo;
      swo_s_q    <= sync1_q;
      swo_prev_q <= swo_s_q;
      state_q    <= state_d;
      period_q   <= period_d;
      nbits_q    <= nbits_d;
      nstop_q    <= nstop_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_bus.O_data          = data_q;
  assign rx_bus.O_data_valid    = valid_q;
  assign rx_bus.O_framing_error = ferr_q;
  assign rx_bus.O_busy          = (state_q != SWO_RX_IDLE);

`ifdef SWO_RX_STATS_EN
  logic [pCNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [pCNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (valid_q && byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 1'b1;
    if (ferr_q  && err_cnt_q  != '1) err_cnt_d  = err_cnt_q + 1'b1;
  end

  always_ff @(posedge uart_clk) begin
    if (reset_i) begin
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign O_byte_count  = byte_cnt_q;
  assign O_error_count = err_cnt_q;
`else
  assign O_byte_count  = '0;
  assign O_error_count = '0;
`endif

endmodule
